// File: rtl/rf_scoreboard_pkg.sv
// rtl/rf_scoreboard_pkg.sv - register IDs, sizes and counter type for the Y86-64 register scoreboard
package rf_scoreboard_pkg;
  localparam int unsigned NUM_REGS = 15;
  localparam int unsigned SB_CNT_W = 2;

  typedef logic [SB_CNT_W-1:0] sb_cnt_t;
  typedef logic [3:0]          reg_id_t;

  localparam reg_id_t RAX   = 4'h0;
  localparam reg_id_t RCX   = 4'h1;
  localparam reg_id_t RDX   = 4'h2;
  localparam reg_id_t RBX   = 4'h3;
  localparam reg_id_t RSP   = 4'h4;
  localparam reg_id_t RBP   = 4'h5;
  localparam reg_id_t RSI   = 4'h6;
  localparam reg_id_t RDI   = 4'h7;
  localparam reg_id_t R8    = 4'h8;
  localparam reg_id_t R9    = 4'h9;
  localparam reg_id_t R10   = 4'hA;
  localparam reg_id_t R11   = 4'hB;
  localparam reg_id_t R12   = 4'hC;
  localparam reg_id_t R13   = 4'hD;
  localparam reg_id_t R14   = 4'hE;
  localparam reg_id_t RNONE = 4'hF;

  function automatic logic is_reg(input reg_id_t id);
    return id != RNONE;
  endfunction
endpackage

// File: rtl/rf_sb_counter.sv
// rtl/rf_sb_counter.sv - one register's pending-write counter; applies the net delta with clamp-to-range
module rf_sb_counter #(
  parameter int unsigned CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       inc,
  input  logic [2:0]       dec,
  output logic [CNT_W-1:0] count,
  output logic             nonzero,
  output logic             sat_err
);
  localparam int unsigned    SW  = CNT_W + 3;
  localparam logic [SW-1:0]  MAX = SW'((1 << CNT_W) - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SW-1:0]    up;
  logic [SW-1:0]    net;

  always_comb begin
    cnt_d   = cnt_q;
    sat_err = 1'b0;
    up      = SW'(cnt_q) + SW'(inc);
    net     = up - SW'(dec);
    if (SW'(dec) > up) begin
      cnt_d   = '0;
      sat_err = 1'b1;
    end else if (net > MAX) begin
      cnt_d   = MAX[CNT_W-1:0];
      sat_err = 1'b1;
    end else begin
      cnt_d = net[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign count   = cnt_q;
  assign nonzero = cnt_q != '0;
endmodule

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - decode-stage RAW hazard scoreboard; SB_WAW_STALL_EN limits each register to one write in flight
module rf_scoreboard
  import rf_scoreboard_pkg::*;
#(
  parameter int unsigned CNT_W = SB_CNT_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                d_valid_i,
  input  logic [3:0]          d_srcA_i,
  input  logic [3:0]          d_srcB_i,
  input  logic [3:0]          d_dstE_i,
  input  logic [3:0]          d_dstM_i,
  output logic                d_issue_o,
  output logic                d_stall_o,
  input  logic                W_valid_i,
  input  logic [3:0]          W_dstE_i,
  input  logic [3:0]          W_dstM_i,
  input  logic                k_valid_i,
  input  logic [3:0]          k_dstE_i,
  input  logic [3:0]          k_dstM_i,
  output logic [NUM_REGS-1:0] busy_o,
  output logic                err_o
);
  localparam logic [CNT_W+1:0] CNT_MAX = (CNT_W+2)'((1 << CNT_W) - 1);

  logic [CNT_W-1:0]    cnt [NUM_REGS];
  logic [1:0]          inc [NUM_REGS];
  logic [2:0]          dec [NUM_REGS];
  logic [NUM_REGS-1:0] nz;
  logic [NUM_REGS-1:0] sat_err;
  logic [15:0]         nz_ext;
  logic [CNT_W-1:0]    cnt_e, cnt_m;
  logic [CNT_W+1:0]    inc_one;
  logic                src_hit, sat_hit, waw_hit;
  logic                err_q, err_d;

  // Slot 15 (RNONE) is hard-wired idle so source lookups need no extra guard.
  assign nz_ext = {1'b0, nz};

  always_comb begin
    cnt_e = '0;
    cnt_m = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (d_dstE_i == reg_id_t'(r)) cnt_e = cnt[r];
      if (d_dstM_i == reg_id_t'(r)) cnt_m = cnt[r];
    end
  end

  always_comb begin
    inc_one = (d_dstE_i == d_dstM_i) ? (CNT_W+2)'(2) : (CNT_W+2)'(1);
    src_hit = nz_ext[d_srcA_i] | nz_ext[d_srcB_i];
    sat_hit = (is_reg(d_dstE_i) && ((CNT_W+2)'(cnt_e) + inc_one > CNT_MAX)) ||
              (is_reg(d_dstM_i) && ((CNT_W+2)'(cnt_m) + inc_one > CNT_MAX));
`ifdef SB_WAW_STALL_EN
    waw_hit = (is_reg(d_dstE_i) && nz_ext[d_dstE_i]) ||
              (is_reg(d_dstM_i) && nz_ext[d_dstM_i]);
`else
    waw_hit = 1'b0;
`endif
    d_stall_o = d_valid_i & (src_hit | sat_hit | waw_hit);
    d_issue_o = d_valid_i & ~d_stall_o;
  end

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
    localparam reg_id_t ID = reg_id_t'(r);

    assign inc[r] = {1'b0, d_issue_o & (d_dstE_i == ID)} +
                    {1'b0, d_issue_o & (d_dstM_i == ID)};
    assign dec[r] = {2'b00, W_valid_i & (W_dstE_i == ID)} +
                    {2'b00, W_valid_i & (W_dstM_i == ID)} +
                    {2'b00, k_valid_i & (k_dstE_i == ID)} +
                    {2'b00, k_valid_i & (k_dstM_i == ID)};

    rf_sb_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk     (clk),
      .rst     (rst),
      .inc     (inc[r]),
      .dec     (dec[r]),
      .count   (cnt[r]),
      .nonzero (nz[r]),
      .sat_err (sat_err[r])
    );
  end

  always_comb begin
    err_d = err_q | (|sat_err);
  end

  always_ff @(posedge clk) begin
    if (!rst) err_q <= 1'b0;
    else      err_q <= err_d;
  end

  assign busy_o = nz;
  assign err_o  = err_q;
endmodule
